// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared codes and state encoding for the store path
package store_pkg;

  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

endpackage

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - pipeline store handshake and bus write signals
interface store_unit_if;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  StoreSel;
  logic        st_done;
  logic        st_fault;
  logic [1:0]  st_fault_cause;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport slave (
    input  st_valid, st_addr, st_data, StoreSel, mem_ack,
    output st_ready, st_done, st_fault, st_fault_cause,
           mem_req, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output st_valid, st_addr, st_data, StoreSel, mem_ack,
    input  st_ready, st_done, st_fault, st_fault_cause,
           mem_req, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - lane replication, byte strobes and legality flags for one store
module store_aligner
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [2:0]  sel,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    wdata      = data;
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (sel)
      SB: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SH: begin
        wdata      = {2{data[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SW: begin
        wstrb      = 4'b1111;
        misaligned = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - accepts pipeline stores and drives one word-aligned bus write each
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst_n,
  store_unit_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  cause_e            cause_q, cause_d;
  logic              ready_q, ready_d;

  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic              al_misaligned;
  logic              al_illegal;
  logic              accept;
  logic              timeout;

  store_aligner u_aligner (
    .addr_lo    (bus.st_addr[1:0]),
    .data       (bus.st_data),
    .sel        (bus.StoreSel),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign accept  = bus.st_valid & ready_q;
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !al_misaligned && !al_illegal) state_d = BUS;
      BUS:  if (bus.mem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack on the timeout cycle is checked first, so it wins over the fault
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    cause_d = CAUSE_NONE;
    ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (al_illegal) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (al_misaligned) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            addr_d  = {bus.st_addr[31:2], 2'b00};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        if (bus.mem_ack) begin
          done_d = 1'b1;
        end else if (timeout) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      ready_q <= ready_d;
    end
  end

  assign bus.st_ready       = ready_q;
  assign bus.st_done        = done_q;
  assign bus.st_fault       = fault_q;
  assign bus.st_fault_cause = cause_q;
  assign bus.mem_req        = (state_q == BUS);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wstrb      = wstrb_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed checks of store_unit alignment, faults, timeout and reset
module tb_store_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  store_unit_if sif ();

  store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store_ok(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] sel, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    sif.st_valid = 1'b1;
    sif.st_addr  = addr;
    sif.st_data  = data;
    sif.StoreSel = sel;
    tick();
    sif.st_valid = 1'b0;
    check({tag, "_req"},   32'(sif.mem_req),   32'd1);
    check({tag, "_addr"},  sif.mem_addr,       exp_addr);
    check({tag, "_wdata"}, sif.mem_wdata,      exp_wdata);
    check({tag, "_wstrb"}, 32'(sif.mem_wstrb), 32'(exp_wstrb));
    check({tag, "_busy"},  32'(sif.st_ready),  32'd0);
    sif.mem_ack = 1'b1;
    tick();
    sif.mem_ack = 1'b0;
    check({tag, "_done"},  32'(sif.st_done),   32'd1);
    check({tag, "_nflt"},  32'(sif.st_fault),  32'd0);
    check({tag, "_rdrop"}, 32'(sif.mem_req),   32'd0);
    check({tag, "_rdy"},   32'(sif.st_ready),  32'd1);
    tick();
    check({tag, "_done0"}, 32'(sif.st_done),   32'd0);
  endtask

  task automatic store_fault(input string tag, input logic [31:0] addr,
                             input logic [2:0] sel, input logic [1:0] exp_cause);
    sif.st_valid = 1'b1;
    sif.st_addr  = addr;
    sif.st_data  = 32'hCAFE_F00D;
    sif.StoreSel = sel;
    tick();
    sif.st_valid = 1'b0;
    check({tag, "_flt"},   32'(sif.st_fault),       32'd1);
    check({tag, "_cause"}, 32'(sif.st_fault_cause), 32'(exp_cause));
    check({tag, "_req"},   32'(sif.mem_req),        32'd0);
    check({tag, "_ndone"}, 32'(sif.st_done),        32'd0);
    check({tag, "_rdy"},   32'(sif.st_ready),       32'd1);
    tick();
    check({tag, "_flt0"},  32'(sif.st_fault),       32'd0);
    check({tag, "_req0"},  32'(sif.mem_req),        32'd0);
  endtask

  initial begin
    int cycles;
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    sif.st_valid = 1'b0;
    sif.st_addr  = '0;
    sif.st_data  = '0;
    sif.StoreSel = '0;
    sif.mem_ack  = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(sif.st_ready), 32'd0);
    check("rst_req",   32'(sif.mem_req),  32'd0);
    check("rst_done",  32'(sif.st_done),  32'd0);
    check("rst_fault", 32'(sif.st_fault), 32'd0);
    check("rst_cause", 32'(sif.st_fault_cause), 32'd0);
    check("rst_addr",  sif.mem_addr,      32'd0);
    check("rst_wdata", sif.mem_wdata,     32'd0);
    check("rst_wstrb", 32'(sif.mem_wstrb), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(sif.st_ready), 32'd1);

    sif.mem_ack = 1'b1;
    tick();
    sif.mem_ack = 1'b0;
    check("idle_ack_done", 32'(sif.st_done), 32'd0);
    check("idle_ack_req",  32'(sif.mem_req), 32'd0);

    store_ok("sb3",  32'h0000_1003, 32'h0000_00A5, 3'd0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    store_ok("sb1",  32'h0000_1001, 32'h1234_565A, 3'd0, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0010);
    store_ok("sh2",  32'h0000_2002, 32'h1234_BEEF, 3'd1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    store_ok("sh0",  32'h0000_2000, 32'h1234_BEEF, 3'd1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011);
    store_ok("sw",   32'h0000_3000, 32'hDEAD_BEEF, 3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);

    store_fault("sw_mis", 32'h0000_3001, 3'd2, 2'd1);
    store_fault("sh_mis", 32'h0000_2001, 3'd1, 2'd1);
    store_fault("sel3",   32'h0000_3000, 3'd3, 2'd2);
    store_fault("sel7",   32'h0000_3001, 3'd7, 2'd2);

    // timeout with ack withheld: mem_req must stay up exactly 8 cycles
    sif.st_valid = 1'b1;
    sif.st_addr  = 32'h0000_4000;
    sif.st_data  = 32'h0BAD_F00D;
    sif.StoreSel = 3'd2;
    tick();
    sif.st_valid = 1'b0;
    cycles = 0;
    while (sif.mem_req && cycles < 20) begin
      cycles++;
      tick();
    end
    check("to_cycles", 32'(cycles),                32'd8);
    check("to_fault",  32'(sif.st_fault),          32'd1);
    check("to_cause",  32'(sif.st_fault_cause),    32'd3);
    check("to_ndone",  32'(sif.st_done),           32'd0);
    tick();
    check("to_flt0",   32'(sif.st_fault),          32'd0);

    // ack on the last allowed cycle beats the timeout
    sif.st_valid = 1'b1;
    tick();
    sif.st_valid = 1'b0;
    repeat (7) tick();
    check("late_req",  32'(sif.mem_req),  32'd1);
    sif.mem_ack = 1'b1;
    tick();
    sif.mem_ack = 1'b0;
    check("late_done", 32'(sif.st_done),  32'd1);
    check("late_nflt", 32'(sif.st_fault), 32'd0);
    tick();
    check("late_flt0", 32'(sif.st_fault), 32'd0);

    // back-to-back: valid and ack held high
    sif.st_valid = 1'b1;
    sif.st_addr  = 32'h0000_5000;
    sif.st_data  = 32'h1111_1111;
    sif.StoreSel = 3'd2;
    tick();
    check("b2b1_wdata", sif.mem_wdata,      32'h1111_1111);
    check("b2b1_busy",  32'(sif.st_ready),  32'd0);
    sif.st_data = 32'h2222_2222;
    sif.mem_ack = 1'b1;
    tick();
    check("b2b1_done",  32'(sif.st_done),   32'd1);
    check("b2b1_rdy",   32'(sif.st_ready),  32'd1);
    tick();
    sif.st_valid = 1'b0;
    check("b2b2_req",   32'(sif.mem_req),   32'd1);
    check("b2b2_wdata", sif.mem_wdata,      32'h2222_2222);
    check("b2b2_done0", 32'(sif.st_done),   32'd0);
    tick();
    sif.mem_ack = 1'b0;
    check("b2b2_done",  32'(sif.st_done),   32'd1);
    tick();
    check("b2b_idle",   32'(sif.mem_req),   32'd0);

    // reset in the middle of a bus transaction
    sif.st_valid = 1'b1;
    sif.st_addr  = 32'h0000_6000;
    sif.st_data  = 32'h3333_3333;
    tick();
    sif.st_valid = 1'b0;
    check("mr_req", 32'(sif.mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr_req0",  32'(sif.mem_req),  32'd0);
    check("mr_rdy0",  32'(sif.st_ready), 32'd0);
    check("mr_done0", 32'(sif.st_done),  32'd0);
    check("mr_flt0",  32'(sif.st_fault), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_rdy1",  32'(sif.st_ready), 32'd1);
    check("mr_done1", 32'(sif.st_done),  32'd0);
    check("mr_flt1",  32'(sif.st_fault), 32'd0);
    repeat (10) begin
      tick();
      check("mr_quiet", 32'(sif.st_done | sif.st_fault | sif.mem_req), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
